ram_if: RTL and testbench



---
 rtl/ram_if.sv | 172 +++++++++++++++++
 tb/tb_ram_if.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_if.sv
// ram_if: registered SRAM strobe sequencer for a multiplexed address/data bus.
// Optional RAM_IF_ADDR_SKIP_EN skips the address phase for a repeated address.
module ram_if #(
   parameter int WORD_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic              clock,
   input  logic              n_reset,
   input  logic              req,
   input  logic              we,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic              busy,
   output logic              ack,
   output logic              RAM_ADDRCP,
   output logic              RAM_NCE,
   output logic              RAM_NOE,
   output logic              RAM_NWE,
   inout  wire  [WORD_W-1:0] sysbus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ADDR   = 3'd1;
   localparam logic [2:0] S_AHOLD  = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_RECOV  = 3'd4;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

   logic [2:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdat_q, wdat_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic [WORD_W-1:0] bus_q, bus_d;
   logic              drv_q, drv_d;
   logic              acp_q, acp_d;
   logic              nce_q, nce_d;
   logic              noe_q, noe_d;
   logic              nwe_q, nwe_d;
   logic              ack_q, ack_d;
   logic              busy_q, busy_d;
   logic              hit;
   logic              st_addr_ph;
   logic              st_data_ph;

`ifdef RAM_IF_ADDR_SKIP_EN
   logic [WORD_W-1:0] last_q, last_d;
   logic              lvld_q, lvld_d;

   assign hit = lvld_q && (addr == last_q);

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         last_q <= '0;
         lvld_q <= 1'b0;
      end else begin
         last_q <= last_d;
         lvld_q <= lvld_d;
      end
   end
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdata_d = rdata_q;
`ifdef RAM_IF_ADDR_SKIP_EN
      last_d  = last_q;
      lvld_d  = lvld_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               we_d   = we;
               addr_d = addr;
               wdat_d = wdata;
               if (hit) begin
                  state_d = S_ACCESS;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = S_ADDR;
`ifdef RAM_IF_ADDR_SKIP_EN
                  last_d  = addr;
                  lvld_d  = 1'b1;
`endif
               end
            end
         end
         S_ADDR:  state_d = S_AHOLD;
         S_AHOLD: begin
            state_d = S_ACCESS;
            cnt_d   = CNT_LOAD;
         end
         S_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RECOV;
               if (!we_q) rdata_d = sysbus;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RECOV: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes and bus enable decode the next state so they register cleanly.
   always_comb begin
      st_addr_ph = (state_d == S_ADDR) || (state_d == S_AHOLD);
      st_data_ph = (state_d == S_ACCESS) || (state_d == S_RECOV);
      acp_d  = (state_d == S_ADDR);
      nce_d  = !(state_d == S_ACCESS);
      noe_d  = !((state_d == S_ACCESS) && !we_d);
      nwe_d  = !((state_d == S_ACCESS) && we_d);
      ack_d  = (state_d == S_RECOV);
      busy_d = (state_d != S_IDLE);
      drv_d  = st_addr_ph || (we_d && st_data_ph);
      bus_d  = st_addr_ph ? addr_d : wdat_d;
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdata_q <= '0;
         bus_q   <= '0;
         drv_q   <= 1'b0;
         acp_q   <= 1'b0;
         nce_q   <= 1'b1;
         noe_q   <= 1'b1;
         nwe_q   <= 1'b1;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdata_q <= rdata_d;
         bus_q   <= bus_d;
         drv_q   <= drv_d;
         acp_q   <= acp_d;
         nce_q   <= nce_d;
         noe_q   <= noe_d;
         nwe_q   <= nwe_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
      end
   end

   assign sysbus     = drv_q ? bus_q : {WORD_W{1'bz}};
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign ack        = ack_q;
   assign RAM_ADDRCP = acp_q;
   assign RAM_NCE    = nce_q;
   assign RAM_NOE    = noe_q;
   assign RAM_NWE    = nwe_q;

endmodule

// File: tb/tb_ram_if.sv
// tb_ram_if: bench for ram_if with an external SRAM + address latch model.
// Released bus reads as 0xFF through the pull-up on each bus net.
module tb_ram_if;

   localparam int W = 2;

   logic       clock;
   logic       n_reset;
   logic       req, we;
   logic [7:0] addr, wdata, rdata;
   logic       busy, ack, acp, nce, noe, nwe;
   tri1  [7:0] sysbus;

   logic       req1, we1;
   logic [7:0] addr1, wdata1, rdata1;
   logic       busy1, ack1, acp1, nce1, noe1, nwe1;
   tri1  [7:0] sb1;

   int checks = 0;
   int errors = 0;

   ram_if #(.WORD_W(8), .WAIT_CYC(W)) u0 (
      .clock(clock), .n_reset(n_reset), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .ack(ack),
      .RAM_ADDRCP(acp), .RAM_NCE(nce), .RAM_NOE(noe), .RAM_NWE(nwe),
      .sysbus(sysbus)
   );

   ram_if #(.WORD_W(8), .WAIT_CYC(1)) u1 (
      .clock(clock), .n_reset(n_reset), .req(req1), .we(we1),
      .addr(addr1), .wdata(wdata1), .rdata(rdata1), .busy(busy1), .ack(ack1),
      .RAM_ADDRCP(acp1), .RAM_NCE(nce1), .RAM_NOE(noe1), .RAM_NWE(nwe1),
      .sysbus(sb1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // External SRAM behind an address latch clocked by RAM_ADDRCP.
   logic [7:0] mem [256];
   logic [7:0] lat;

   always @(negedge clock) begin
      if (!n_reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5C;
         lat <= 8'h00;
      end else begin
         if (acp) lat <= sysbus;
         if (!nce && !nwe) mem[lat] <= sysbus;
      end
   end

   assign sysbus = (!nce && !noe) ? mem[lat] : 8'hzz;
   assign sb1    = (!nce1 && !noe1) ? 8'h5A : 8'hzz;

   // Reference model state.
   logic [7:0] ref_mem [256];
   logic [7:0] exp_rd;
   logic       last_vld;
   logic [7:0] last_addr;

   task automatic ref_init();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5C;
      exp_rd   = 8'h00;
      last_vld = 1'b0;
      last_addr = 8'h00;
   endtask

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %02h expected %02h", nm, $time, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0t: got %0b expected %0b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk1({tag, "_acp"}, acp, 1'b0);
      chk1({tag, "_nce"}, nce, 1'b1);
      chk1({tag, "_noe"}, noe, 1'b1);
      chk1({tag, "_nwe"}, nwe, 1'b1);
      chk1({tag, "_ack"}, ack, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_rdata"}, rdata, exp_rd);
      chk({tag, "_busz"}, sysbus, 8'hFF);
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      req = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clock);
      ref_init();
      chk_idle("rst");
      chk1("rst1_nce", nce1, 1'b1);
      chk1("rst1_ack", ack1, 1'b0);
      chk("rst1_rdata", rdata1, 8'h00);
      n_reset = 1'b1;
   endtask

   // One complete access starting from an IDLE cycle; returns in the
   // following IDLE cycle. Expected waveform comes from the access timeline.
   task automatic access(input logic w, input logic [7:0] a,
                         input logic [7:0] d, input bit hold);
      bit skip;
      int lat_c;
      bit is_ad, is_ah, is_acc, is_rec;
      skip = 1'b0;
`ifdef RAM_IF_ADDR_SKIP_EN
      skip = last_vld && (a == last_addr);
`endif
      if (!skip) begin
         last_vld  = 1'b1;
         last_addr = a;
      end
      lat_c = skip ? 1 + W : 3 + W;
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clock);
      for (int k = 1; k <= lat_c; k++) begin
         @(negedge clock);
         is_ad  = !skip && (k == 1);
         is_ah  = !skip && (k == 2);
         is_acc = (k >= lat_c - W) && (k < lat_c);
         is_rec = (k == lat_c);
         if (is_rec && !w) exp_rd = ref_mem[a];
         chk1("acp", acp, is_ad);
         chk1("nce", nce, !is_acc);
         chk1("noe", noe, !(is_acc && !w));
         chk1("nwe", nwe, !(is_acc && w));
         chk1("ack", ack, is_rec);
         chk1("busy", busy, 1'b1);
         chk("rdata", rdata, exp_rd);
         if (is_ad || is_ah) chk("bus_addr", sysbus, a);
         else if (w) chk("bus_wdata", sysbus, d);
         else if (is_rec) chk("bus_relz", sysbus, 8'hFF);
         req   = hold ? 1'b1 : 1'($urandom);
         we    = 1'($urandom);
         addr  = 8'($urandom);
         wdata = 8'($urandom);
      end
      if (w) ref_mem[a] = d;
      @(negedge clock);
      chk_idle("idle");
      req = 1'b0;
   endtask

   typedef struct {
      logic       w;
      logic [7:0] a;
      logic [7:0] d;
      bit         hold;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int noe_cnt;
      int ack_cyc;
      logic [7:0] rd1;
      logic aw;
      logic [7:0] aa, ad;

      tbl[0] = '{1'b1, 8'h3C, 8'hA5, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5};
      tbl[2] = '{1'b1, 8'h10, 8'h77, 1'b0, 8'hA5};
      tbl[3] = '{1'b0, 8'h10, 8'h00, 1'b1, 8'h77};
      tbl[4] = '{1'b0, 8'h3C, 8'h00, 1'b0, 8'hA5};
      tbl[5] = '{1'b0, 8'h20, 8'h00, 1'b0, 8'h7C};
      tbl[6] = '{1'b0, 8'h20, 8'h00, 1'b0, 8'h7C};
      tbl[7] = '{1'b0, 8'h21, 8'h00, 1'b0, 8'h7D};

      req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
      req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
      do_reset();

      for (int i = 0; i < 8; i++) begin
         access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].hold);
         chk("tbl_rdata", rdata, tbl[i].exp);
      end

      // Reset in the second write ACCESS cycle.
      req = 1'b1; we = 1'b1; addr = 8'h44; wdata = 8'hC3;
      @(posedge clock);
      @(negedge clock); req = 1'b0;
      @(negedge clock);
      @(negedge clock); chk1("mr_nwe_c3", nwe, 1'b0);
      @(negedge clock); chk1("mr_nwe_c4", nwe, 1'b0);
      n_reset = 1'b0;
      @(negedge clock);
      chk1("mr_nwe", nwe, 1'b1);
      chk1("mr_nce", nce, 1'b1);
      chk("mr_busz", sysbus, 8'hFF);
      chk1("mr_ack", ack, 1'b0);
      chk1("mr_busy", busy, 1'b0);
      chk("mr_rdata", rdata, 8'h00);
      @(negedge clock);
      ref_init();
      n_reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk1("mr_noack", ack, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         aw = 1'($urandom);
         aa = 8'h20 + 8'($urandom_range(0, 7));
         ad = 8'($urandom);
         access(aw, aa, ad, 1'($urandom));
      end

      // WAIT_CYC=1 instance: single NOE-low cycle, ack in cycle 4.
      noe_cnt = 0;
      ack_cyc = 0;
      rd1 = 8'h00;
      req1 = 1'b1; we1 = 1'b0; addr1 = 8'hFF; wdata1 = 8'h00;
      @(posedge clock);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clock);
         req1 = 1'b0;
         if (!noe1) noe_cnt++;
         if (ack1 && ack_cyc == 0) ack_cyc = k;
         if (k == 4) rd1 = rdata1;
         if (k == 1) chk("w1_busaddr", sb1, 8'hFF);
      end
      chk("w1_noe_cycles", 8'(noe_cnt), 8'd1);
      chk("w1_ack_cycle", 8'(ack_cyc), 8'd4);
      chk("w1_rdata", rd1, 8'h5A);
      chk("w1_rdata_hold", rdata1, 8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
